// File: rtl/xor_end.sv
// End-of-permutation XOR stage for the ASCON datapath: key/domain XORs on the
// outgoing state, a show-ahead ciphertext FIFO and a handshaked tag register.

package xor_end_pkg;
    typedef logic [4:0][63:0] type_state;
endpackage

module xor_end
    import xor_end_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               en_xor_key_i,
    input  logic               en_xor_lsb_i,
    input  type_state          state_i,
    input  logic [127:0]       key_i,
    output type_state          state_o,
    input  logic               clear_i,
    input  logic               cipher_capture_i,
    output logic [63:0]        cipher_data_o,
    output logic               cipher_valid_o,
    input  logic               cipher_ready_i,
    output logic               cipher_full_o,
    output logic [CNT_W-1:0]   block_cnt_o,
    input  logic               tag_capture_i,
    input  logic [127:0]       tag_expected_i,
    output logic [127:0]       tag_o,
    output logic               tag_valid_o,
    input  logic               tag_ready_i,
    output logic               tag_match_o,
    output logic               error_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_HOLD = 1'b1
    } tag_state_t;

    logic             flush_s;
    logic [63:0]      mem_r      [FIFO_DEPTH];
    logic [63:0]      mem_next_s [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_next_s;
    logic [OCC_W-1:0] occ_r, occ_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             full_s, push_s, pop_s, cipher_drop_s;

    tag_state_t       tag_state_r, tag_state_next_s;
    logic [127:0]     tag_word_s, tag_next_s;
    logic             match_next_s, tag_drop_s;

    assign flush_s = reset_i || clear_i;

    // End XORs: x0..x2 pass through, key into x3/x4, domain bit into x4 LSB.
    always_comb begin
        state_o    = state_i;
        state_o[3] = state_i[3] ^ (en_xor_key_i ? key_i[127:64] : 64'd0);
        state_o[4] = state_i[4] ^ (en_xor_key_i ? key_i[63:0] : 64'd0)
                   ^ {63'd0, en_xor_lsb_i};
    end

    // A full FIFO can still accept a block when the head leaves in the same cycle.
    always_comb begin
        full_s        = (occ_r == OCC_FULL);
        pop_s         = cipher_valid_o && cipher_ready_i;
        push_s        = cipher_capture_i && (!full_s || pop_s);
        cipher_drop_s = cipher_capture_i && full_s && !pop_s;
    end

    // Next FIFO contents, pointers, occupancy and saturating block counter.
    always_comb begin
        mem_next_s    = mem_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        cnt_next_s    = block_cnt_o;
        if (push_s) begin
            mem_next_s[wr_ptr_r] = state_i[0];
            wr_ptr_next_s        = wr_ptr_r + PTR_W'(1);
            cnt_next_s           = (block_cnt_o != CNT_MAX) ? block_cnt_o + CNT_W'(1) : block_cnt_o;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + OCC_W'(1);
            2'b01:   occ_next_s = occ_r - OCC_W'(1);
            default: occ_next_s = occ_r;
        endcase
    end

    // FIFO storage and registered show-ahead head/flags.
    always_ff @(posedge clock_i) begin
        if (flush_s) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            occ_r          <= '0;
            block_cnt_o    <= '0;
            cipher_data_o  <= 64'd0;
            cipher_valid_o <= 1'b0;
            cipher_full_o  <= 1'b0;
        end else begin
            mem_r          <= mem_next_s;
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            occ_r          <= occ_next_s;
            block_cnt_o    <= cnt_next_s;
            cipher_data_o  <= mem_next_s[rd_ptr_next_s];
            cipher_valid_o <= (occ_next_s != OCC_W'(0));
            cipher_full_o  <= (occ_next_s == OCC_FULL);
        end
    end

    assign tag_word_s = {state_o[3], state_o[4]};

    // Tag FSM next state; a release clears the match flag but keeps the tag.
    always_comb begin
        tag_state_next_s = tag_state_r;
        tag_next_s       = tag_o;
        match_next_s     = tag_match_o;
        tag_drop_s       = 1'b0;
        case (tag_state_r)
            T_IDLE: begin
                if (tag_capture_i) begin
                    tag_state_next_s = T_HOLD;
                    tag_next_s       = tag_word_s;
                    match_next_s     = (tag_word_s == tag_expected_i);
                end else begin
                    tag_state_next_s = T_IDLE;
                end
            end
            T_HOLD: begin
                if (tag_ready_i && tag_capture_i) begin
                    tag_state_next_s = T_HOLD;
                    tag_next_s       = tag_word_s;
                    match_next_s     = (tag_word_s == tag_expected_i);
                end else if (tag_ready_i) begin
                    tag_state_next_s = T_IDLE;
                    match_next_s     = 1'b0;
                end else if (tag_capture_i) begin
                    tag_drop_s = 1'b1;
                end else begin
                    tag_state_next_s = T_HOLD;
                end
            end
            default: begin
                tag_state_next_s = T_IDLE;
                match_next_s     = 1'b0;
            end
        endcase
    end

    // Tag FSM state and registered tag outputs.
    always_ff @(posedge clock_i) begin
        if (flush_s) begin
            tag_state_r <= T_IDLE;
            tag_o       <= 128'd0;
            tag_valid_o <= 1'b0;
            tag_match_o <= 1'b0;
        end else begin
            tag_state_r <= tag_state_next_s;
            tag_o       <= tag_next_s;
            tag_valid_o <= (tag_state_next_s == T_HOLD);
            tag_match_o <= match_next_s;
        end
    end

    // Sticky error for any dropped cipher push or tag capture.
    always_ff @(posedge clock_i) begin
        if (flush_s) begin
            error_o <= 1'b0;
        end else begin
            error_o <= error_o | cipher_drop_s | tag_drop_s;
        end
    end

endmodule
